mpmc10_port_arb: RTL and testbench

- Port arbiter for the mpmc10 multi-port memory controller; decides which client channel the memory state machine services next.
- Watches the controller state bus, grants one requester at a time, and holds the grant until the transaction returns the controller to IDLE.
- Round-robin fairness plus per-port age counters; a starving port is promoted ahead of the rotation.

---
 rtl/mpmc10_port_arb_pkg.sv | 15 +
 rtl/mpmc10_rr_pick.sv | 41 ++++
 rtl/mpmc10_port_arb.sv | 155 +++++++++++++++
 tb/tb_mpmc10_port_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc10_port_arb_pkg.sv
// Shared arbiter types and constants for the mpmc10 port arbiter.
// IDLE mirrors the controller's idle state encoding.
package mpmc10_port_arb_pkg;

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [7:0] ARB_STARVE = 8'd200;
    localparam logic [9:0] ARB_GNT_TO = 10'd1023;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_GRANT = 2'd1,
        A_BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mpmc10_rr_pick.sv
// Combinational picker: lowest-index starving requester first,
// otherwise the first requester after 'last' in round-robin order.
module mpmc10_rr_pick #(
    parameter int NPORT = 8,
    parameter int SEL_W = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [NPORT-1:0] starving,
    output logic [SEL_W-1:0] win,
    output logic             found,
    output logic             by_starve
);

    logic [NPORT-1:0] hot_s;
    int               idx_s;

    // Scans run high-to-low so the final assignment is the highest-priority hit.
    always_comb begin
        hot_s     = req & starving;
        win       = '0;
        found     = 1'b0;
        by_starve = 1'b0;
        idx_s     = 0;
        if (|hot_s) begin
            found     = 1'b1;
            by_starve = 1'b1;
            for (int i = NPORT - 1; i >= 0; i--) begin
                win = hot_s[i] ? SEL_W'(i) : win;
            end
        end else begin
            for (int off = NPORT; off >= 1; off--) begin
                idx_s = int'(last) + off;
                idx_s = (idx_s >= NPORT) ? (idx_s - NPORT) : idx_s;
                win   = req[idx_s] ? SEL_W'(idx_s) : win;
                found = req[idx_s] ? 1'b1 : found;
            end
        end
    end

endmodule

// File: rtl/mpmc10_port_arb.sv
// mpmc10 port arbiter: grants one channel at a time and holds the grant
// until the controller passes through a transaction and returns to IDLE.
module mpmc10_port_arb
    import mpmc10_port_arb_pkg::*;
#(
    parameter int               NPORT  = 8,
    parameter int               AGE_W  = 8,
    parameter logic [AGE_W-1:0] STARVE = AGE_W'(ARB_STARVE),
    parameter logic [9:0]       GNT_TO = ARB_GNT_TO,
    localparam int              SEL_W  = $clog2(NPORT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic [3:0]       state,
    output logic [NPORT-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_v,
    output logic             starve,
    output logic             to
);

    arb_state_t       fsm_q, fsm_d;
    logic [NPORT-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             sel_v_q, sel_v_d;
    logic             starve_q, starve_d;
    logic             to_q, to_d;
    logic [9:0]       tmr_q, tmr_d;
    logic [AGE_W-1:0] age_q [NPORT];
    logic [AGE_W-1:0] age_d [NPORT];
    logic [NPORT-1:0] starving_s;
    logic [SEL_W-1:0] win_s;
    logic             found_s;
    logic             by_starve_s;

    mpmc10_rr_pick #(.NPORT(NPORT), .SEL_W(SEL_W)) u_pick (
        .req       (req),
        .last      (last_q),
        .starving  (starving_s),
        .win       (win_s),
        .found     (found_s),
        .by_starve (by_starve_s)
    );

    // Per-port waiting age: cleared when idle or granted, saturates otherwise.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            if (!req[i] || gnt_q[i]) begin
                age_d[i] = '0;
            end else if (&age_q[i]) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
            starving_s[i] = (age_q[i] >= STARVE);
        end
    end

    // Grant FSM next-state; every release path drops gnt, sel_v and starve together.
    always_comb begin
        fsm_d    = fsm_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        sel_v_d  = sel_v_q;
        starve_d = starve_q;
        last_d   = last_q;
        tmr_d    = tmr_q;
        to_d     = 1'b0;
        case (fsm_q)
            A_IDLE: begin
                if ((state == IDLE) && found_s) begin
                    gnt_d    = NPORT'(1) << win_s;
                    sel_d    = win_s;
                    sel_v_d  = 1'b1;
                    starve_d = by_starve_s;
                    tmr_d    = 10'd0;
                    fsm_d    = A_GRANT;
                end else begin
                    fsm_d = A_IDLE;
                end
            end
            A_GRANT: begin
                if (state != IDLE) begin
                    tmr_d = 10'd0;
                    fsm_d = A_BUSY;
                end else if (!req[sel_q] || (tmr_q == GNT_TO)) begin
                    to_d     = req[sel_q];
                    gnt_d    = '0;
                    sel_v_d  = 1'b0;
                    starve_d = 1'b0;
                    tmr_d    = 10'd0;
                    fsm_d    = A_IDLE;
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            A_BUSY: begin
                if (state == IDLE) begin
                    last_d   = sel_q;
                    gnt_d    = '0;
                    sel_v_d  = 1'b0;
                    starve_d = 1'b0;
                    fsm_d    = A_IDLE;
                end else begin
                    fsm_d = A_BUSY;
                end
            end
            default: begin
                gnt_d    = '0;
                sel_v_d  = 1'b0;
                starve_d = 1'b0;
                tmr_d    = 10'd0;
                fsm_d    = A_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; last starts at NPORT-1 so port 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= A_IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            sel_v_q  <= 1'b0;
            starve_q <= 1'b0;
            to_q     <= 1'b0;
            last_q   <= SEL_W'(NPORT - 1);
            tmr_q    <= 10'd0;
            for (int i = 0; i < NPORT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            fsm_q    <= fsm_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            sel_v_q  <= sel_v_d;
            starve_q <= starve_d;
            to_q     <= to_d;
            last_q   <= last_d;
            tmr_q    <= tmr_d;
            for (int i = 0; i < NPORT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign sel_v  = sel_v_q;
    assign starve = starve_q;
    assign to     = to_q;

endmodule

// File: tb/tb_mpmc10_port_arb.sv
// Bench for mpmc10_port_arb: directed scenarios plus a random phase, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_mpmc10_port_arb;

    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [3:0] state;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_v;
    logic       starve;
    logic       to;

    int checks = 0;
    int errors = 0;

    int m_phase, m_sel, m_last, m_tmr;
    bit m_v, m_starve, m_to;
    int m_age [NP];

    int busy_cnt, to_cnt;
    bit ok, saw_starve;

    always #5 clk = ~clk;

    mpmc10_port_arb dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .state  (state),
        .gnt    (gnt),
        .sel    (sel),
        .sel_v  (sel_v),
        .starve (starve),
        .to     (to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: applies the arbitration rules for one clock edge.
    task automatic model_edge();
        int nage [NP];
        bit hit;
        int idx;
        if (rst) begin
            m_phase = 0; m_v = 0; m_sel = 0; m_starve = 0; m_to = 0;
            m_last = NP - 1; m_tmr = 0;
            for (int i = 0; i < NP; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (req[i] == 1'b0 || (m_v && m_sel == i)) nage[i] = 0;
                else nage[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
            end
            m_to = 0;
            if (m_phase == 0) begin
                if (state == 4'd0 && req != 8'd0) begin
                    hit = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (!hit && req[i] && m_age[i] >= 200) begin
                            hit = 1; m_sel = i; m_starve = 1;
                        end
                    end
                    for (int off = 1; off <= NP; off++) begin
                        idx = (m_last + off) % NP;
                        if (!hit && req[idx]) begin
                            hit = 1; m_sel = idx; m_starve = 0;
                        end
                    end
                    m_v = 1; m_phase = 1; m_tmr = 0;
                end
            end else if (m_phase == 1) begin
                if (state != 4'd0) begin
                    m_phase = 2; m_tmr = 0;
                end else if (!req[m_sel]) begin
                    m_v = 0; m_starve = 0; m_phase = 0;
                end else if (m_tmr == 1023) begin
                    m_v = 0; m_starve = 0; m_to = 1; m_phase = 0;
                end else begin
                    m_tmr++;
                end
            end else begin
                if (state == 4'd0) begin
                    m_last = m_sel; m_v = 0; m_starve = 0; m_phase = 0;
                end
            end
            for (int i = 0; i < NP; i++) m_age[i] = nage[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", gnt, m_v ? (32'd1 << m_sel) : 32'd0);
        chk("sel_v", sel_v, m_v);
        chk("starve", starve, m_starve);
        chk("to", to, m_to);
        if (m_v) chk("sel", sel, m_sel);
    endtask

    task automatic wait_grant(input int max_cyc);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!ok) begin
                step();
                ok = (sel_v === 1'b1);
            end
        end
        chk("grant_wait", ok, 1);
    endtask

    task automatic serve(input int busy);
        state = 4'd1;
        repeat (busy) step();
        state = 4'd0;
        step();
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; state = 4'd0;
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_sel_v", sel_v, 0);
        rst = 1'b0;

        // single request: grant after exactly one edge, released after IDLE returns
        req = 8'h01;
        step();
        chk("lat_gnt", gnt, 8'h01);
        chk("lat_sel", sel, 0);
        state = 4'd1;
        repeat (3) step();
        chk("busy_hold", gnt, 8'h01);
        req = 8'h00; state = 4'd0;
        step();
        chk("release", gnt, 0);

        // fair rotation with all ports requesting
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_grant(20);
            chk("rr_sel", sel, (k + 1) % NP);
            chk("rr_starve", starve, 0);
            serve(5);
        end

        // long transactions push waiting ports past the starvation age
        saw_starve = 0;
        for (int k = 0; k < 8; k++) begin
            wait_grant(20);
            saw_starve = saw_starve | (starve === 1'b1);
            serve(40);
        end
        chk("starve_seen", saw_starve, 1);

        // grant timeout with controller stuck in IDLE
        req = 8'h20;
        wait_grant(20);
        chk("to_sel", sel, 5);
        to_cnt = 0;
        for (int i = 0; i < 1030; i++) begin
            step();
            to_cnt = to_cnt + ((to === 1'b1) ? 1 : 0);
        end
        chk("to_count", to_cnt, 1);
        chk("to_regrant_v", sel_v, 1);
        chk("to_regrant_sel", sel, 5);
        state = 4'd1; step(); state = 4'd0; step();

        // request withdrawn while granted
        req = 8'h04;
        wait_grant(20);
        chk("drop_sel", sel, 2);
        req = 8'h00;
        step();
        chk("drop_gnt", gnt, 0);
        chk("drop_to", to, 0);

        // random traffic
        busy_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) req = req ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) req = 8'($urandom);
            if (busy_cnt > 0) begin
                busy_cnt--;
                state = 4'($urandom_range(1, 15));
            end else if (sel_v === 1'b1 && $urandom_range(0, 3) != 0) begin
                busy_cnt = $urandom_range(1, 12);
                state = 4'($urandom_range(1, 15));
            end else if ($urandom_range(0, 49) == 0) begin
                state = 4'($urandom_range(1, 15));
            end else begin
                state = 4'd0;
            end
            step();
        end
        state = 4'd0;
        step();

        // reset while busy
        req = 8'h80;
        state = 4'd0;
        step();
        wait_grant(1100);
        state = 4'd3;
        step(); step();
        rst = 1'b1;
        step();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_sel_v", sel_v, 0);
        rst = 1'b0; state = 4'd0; req = 8'h0C;
        wait_grant(5);
        chk("post_rst_sel", sel, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
